// File: rtl/mcpu_ram_pkg.sv
// Shared defaults and types for the MCPU unified RAM.
// The optional addr_err output is enabled with the MCPU_RAM_ADDR_ERR_EN macro.
package mcpu_ram_pkg;

    localparam int DEF_WORD_SIZE  = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_RAM_SIZE   = 256;

    // Number of read ports on the storage array: data port and fetch port.
    localparam int NUM_RD_PORTS   = 2;
    localparam int PORT_DATA      = 0;
    localparam int PORT_INSTR     = 1;

    typedef logic [DEF_WORD_SIZE-1:0]  word_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

    // True when an address falls inside the populated part of the map.
    function automatic logic addr_in_range(input int unsigned a, input int unsigned ram_size);
        return a < ram_size;
    endfunction

endpackage

// File: rtl/mcpu_ram_array.sv
// Storage for the MCPU RAM: one synchronous write port, NUM_RD_PORTS registered
// read ports, synchronous clear on rst, and write-first bypass on every read port.
// Range checking is done by the caller; ok[] forces a read port to return 0.
module mcpu_ram_array
    import mcpu_ram_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_SIZE   = DEF_RAM_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_SIZE-1:0]  wdata,
    input  logic                  re    [NUM_RD_PORTS],
    input  logic                  ok    [NUM_RD_PORTS],
    input  logic [ADDR_WIDTH-1:0] raddr [NUM_RD_PORTS],
    output logic [WORD_SIZE-1:0]  rdata [NUM_RD_PORTS]
);

    logic [WORD_SIZE-1:0] mem [RAM_SIZE];

    // Word storage: whole-array clear on reset, otherwise single-word write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
            // Registered read port; a same-address write in this cycle wins.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata[gi] <= '0;
                end else if (re[gi]) begin
                    if (!ok[gi]) begin
                        rdata[gi] <= '0;
                    end else if (we && (waddr == raddr[gi])) begin
                        rdata[gi] <= wdata;
                    end else begin
                        rdata[gi] <= mem[raddr[gi]];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mcpu_ram_controller.sv
// MCPU unified data/instruction RAM: a load/store port with read enable and
// an always-enabled fetch port over one shared array.
// Define MCPU_RAM_ADDR_ERR_EN to add the registered addr_err output.
module mcpu_ram_controller
    import mcpu_ram_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_SIZE   = DEF_RAM_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [WORD_SIZE-1:0]  datawr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [WORD_SIZE-1:0]  datard,
    input  logic [ADDR_WIDTH-1:0] instraddr,
`ifdef MCPU_RAM_ADDR_ERR_EN
    output logic                  addr_err,
`endif
    output logic [WORD_SIZE-1:0]  instrrd
);

    logic                  addr_ok;
    logic                  instr_ok;
    logic                  we_eff;
    logic                  rd_re    [NUM_RD_PORTS];
    logic                  rd_ok    [NUM_RD_PORTS];
    logic [ADDR_WIDTH-1:0] rd_addr  [NUM_RD_PORTS];
    logic [WORD_SIZE-1:0]  rd_data  [NUM_RD_PORTS];

    // Range decode for both ports; out-of-range writes are dropped here.
    always_comb begin
        addr_ok  = addr_in_range(32'(addr), RAM_SIZE);
        instr_ok = addr_in_range(32'(instraddr), RAM_SIZE);
        we_eff   = we && addr_ok;

        rd_re[PORT_DATA]    = re;
        rd_ok[PORT_DATA]    = addr_ok;
        rd_addr[PORT_DATA]  = addr;
        rd_re[PORT_INSTR]   = 1'b1;
        rd_ok[PORT_INSTR]   = instr_ok;
        rd_addr[PORT_INSTR] = instraddr;
    end

    mcpu_ram_array #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_SIZE   (RAM_SIZE)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we_eff),
        .waddr (addr),
        .wdata (datawr),
        .re    (rd_re),
        .ok    (rd_ok),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign datard  = rd_data[PORT_DATA];
    assign instrrd = rd_data[PORT_INSTR];

`ifdef MCPU_RAM_ADDR_ERR_EN
    logic addr_err_reg;

    // Flag any cycle that touched an address outside the populated map.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= ((we || re) && !addr_ok) || !instr_ok;
        end
    end

    assign addr_err = addr_err_reg;
`endif

endmodule

// File: tb/tb_mcpu_ram_controller.sv
// Self-checking bench for mcpu_ram_controller (RAM_SIZE = 200 so the
// out-of-range path is reachable with 8-bit addresses).
module tb_mcpu_ram_controller;

    localparam int WS = 8;
    localparam int AW = 8;
    localparam int RS = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [WS-1:0] datawr = '0;
    logic [AW-1:0] addr = '0;
    logic [AW-1:0] instraddr = '0;
    logic [WS-1:0] datard;
    logic [WS-1:0] instrrd;
`ifdef MCPU_RAM_ADDR_ERR_EN
    logic          addr_err;
`endif

    mcpu_ram_controller #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .RAM_SIZE(RS)) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .datawr    (datawr),
        .re        (re),
        .addr      (addr),
        .datard    (datard),
        .instraddr (instraddr),
`ifdef MCPU_RAM_ADDR_ERR_EN
        .addr_err  (addr_err),
`endif
        .instrrd   (instrrd)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [WS-1:0] dr;
        logic [WS-1:0] ir;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    logic [WS-1:0] mem_m [256];
    logic [WS-1:0] dr_m;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input string what,
                       input logic [WS-1:0] obs, input logic [WS-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s %s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input logic r, input logic w, input logic rd,
                        input int a, input int d, input int ia, input string tag);
        exp_t e;
        rst = r; we = w; re = rd;
        addr = AW'(a); datawr = WS'(d); instraddr = AW'(ia);
        e.tag = tag;
        e.err = 1'b0;
        if (r) begin
            for (int i = 0; i < 256; i++) mem_m[i] = '0;
            dr_m = '0;
            e.ir = '0;
        end else begin
            if (w && a < RS) mem_m[a] = WS'(d);
            if (rd) dr_m = (a < RS) ? mem_m[a] : '0;
            e.ir  = (ia < RS) ? mem_m[ia] : '0;
            e.err = ((w || rd) && a >= RS) || ia >= RS;
        end
        e.dr = dr_m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("step %-10s rst=%0b we=%0b re=%0b addr=%0d wr=%h ia=%0d -> datard=%h instrrd=%h",
                 e.tag, r, w, rd, a, d, ia, datard, instrrd);
        chk(e.tag, "datard", datard, e.dr);
        chk(e.tag, "instrrd", instrrd, e.ir);
`ifdef MCPU_RAM_ADDR_ERR_EN
        chk(e.tag, "addr_err", WS'(addr_err), WS'(e.err));
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        dr_m = '0;
        #2;

        // Reset state
        step(1, 0, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, 0, "idle");

        // 1. Random fill and readback on both ports
        for (int i = 0; i < 12; i++) step(0, 1, 0, i, $urandom_range(0, 255), 20, "rnd_wr");
        for (int i = 0; i < 12; i++) step(0, 0, 1, i, 0, i, "rnd_rd");

        // 2. Pattern fill 51,2,51,16 repeating
        for (int i = 0; i < 12; i++) begin
            int pat;
            case (i % 4)
                0: pat = 51;
                1: pat = 2;
                2: pat = 51;
                default: pat = 16;
            endcase
            step(0, 1, 0, i, pat, 30, "pat_wr");
        end
        for (int i = 0; i < 12; i++) step(0, 0, 1, i, 0, i, "pat_rd");
        step(0, 0, 1, 4, 0, 7, "pat_4_7");

        // 3. Hold: datard keeps its value with re low
        step(0, 1, 0, 3, 8'h5A, 0, "hold_wr");
        step(0, 0, 1, 3, 0, 3, "hold_rd");
        step(0, 0, 0, 9, 0, 9, "hold");
        step(0, 0, 0, 10, 0, 1, "hold2");

        // 4. Collision: write-first on both read ports
        step(0, 1, 0, 5, 8'h11, 0, "coll_pre");
        step(0, 0, 1, 5, 0, 5, "coll_old");
        step(0, 1, 1, 5, 8'hC3, 5, "collision");
        step(0, 0, 1, 5, 0, 5, "coll_post");
        step(0, 1, 0, 6, 8'h99, 6, "wr_fetch");

        // 5. Reset mid-sequence with a write that must be lost
        step(1, 1, 1, 2, 8'h77, 2, "rst_wr");
        for (int i = 0; i < 12; i++) step(0, 0, 1, i, 0, 11 - i, "post_rst");

        // 6. Out of range (RAM_SIZE = 200)
        step(0, 1, 0, 199, 8'hAB, 0, "edge_wr");
        step(0, 1, 0, 0, 8'hCD, 199, "low_wr");
        step(0, 1, 0, 210, 8'hFF, 0, "oor_wr");
        step(0, 0, 1, 210, 0, 199, "oor_rd");
        step(0, 0, 1, 199, 0, 200, "oor_fetch");
        step(0, 0, 1, 10, 0, 82, "alias_chk");
        step(0, 0, 1, 0, 0, 250, "oor_fetch2");
        step(0, 0, 0, 210, 0, 0, "oor_idle");
        step(0, 0, 1, 82, 0, 10, "alias_chk2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
